// File: rtl/usrt_tx_ctrl_if.sv
// USRT transmit control bus: request/data from the host side, serial line
// and frame-position status back from the sequencer.
interface usrt_tx_ctrl_if #(
    parameter int DATA_W = 8
);
    logic              start;
    logic [DATA_W-1:0] din;
    logic              par_en;
    logic              en_usrt;
    logic              cts;
    logic              rts;
    logic              txd;
    logic              busy;
    logic              done;
    logic [5:0]        cout;
    logic              max;

    modport master (
        output start, din, par_en, en_usrt, cts,
        input  rts, txd, busy, done, cout, max
    );

    modport slave (
        input  start, din, par_en, en_usrt, cts,
        output rts, txd, busy, done, cout, max
    );
endinterface

// File: rtl/usrt_tx_ctrl.sv
// USRT transmit sequencer: start bit, DATA_W data bits LSB first, optional
// parity, STOP_BITS stop bits; paced by en_usrt, gated by cts before the start bit.
module usrt_tx_ctrl #(
    parameter int DATA_W    = 8,
    parameter int STOP_BITS = 1,
    parameter int PAR_ODD   = 0
) (
    input  logic           clk,
    input  logic           rst,
    usrt_tx_ctrl_if.slave  bus
);
    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] WAIT_CTS = 3'd1;
    localparam logic [2:0] START_B  = 3'd2;
    localparam logic [2:0] DATA     = 3'd3;
    localparam logic [2:0] PARITY   = 3'd4;
    localparam logic [2:0] STOP     = 3'd5;

    localparam logic [5:0] LAST_D = 6'(DATA_W - 1);
    localparam logic [5:0] LAST_S = 6'(STOP_BITS - 1);
    localparam logic       ODD    = (PAR_ODD != 0);

    logic [2:0]        state;
    logic [DATA_W-1:0] shreg;
    logic              par_bit;
    logic              par_en_q;
    logic              txd_q;
    logic              rts_q;
    logic              done_q;
    logic [5:0]        cout;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            shreg    <= '0;
            par_bit  <= 1'b0;
            par_en_q <= 1'b0;
            txd_q    <= 1'b1;
            rts_q    <= 1'b0;
            done_q   <= 1'b0;
            cout     <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        shreg    <= bus.din;
                        par_en_q <= bus.par_en;
                        par_bit  <= (^bus.din) ^ ODD;
                        rts_q    <= 1'b1;
                        state    <= WAIT_CTS;
                    end
                end
                WAIT_CTS: begin
                    if (bus.en_usrt && bus.cts) begin
                        txd_q <= 1'b0;
                        state <= START_B;
                    end
                end
                // shreg[0] always holds the next data bit to launch
                START_B: begin
                    if (bus.en_usrt) begin
                        txd_q <= shreg[0];
                        shreg <= shreg >> 1;
                        cout  <= '0;
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (bus.en_usrt) begin
                        if (cout == LAST_D) begin
                            cout <= '0;
                            if (par_en_q) begin
                                txd_q <= par_bit;
                                state <= PARITY;
                            end else begin
                                txd_q <= 1'b1;
                                state <= STOP;
                            end
                        end else begin
                            txd_q <= shreg[0];
                            shreg <= shreg >> 1;
                            cout  <= cout + 6'd1;
                        end
                    end
                end
                PARITY: begin
                    if (bus.en_usrt) begin
                        txd_q <= 1'b1;
                        cout  <= '0;
                        state <= STOP;
                    end
                end
                STOP: begin
                    if (bus.en_usrt) begin
                        if (cout == LAST_S) begin
                            done_q <= 1'b1;
                            rts_q  <= 1'b0;
                            cout   <= '0;
                            state  <= IDLE;
                        end else begin
                            cout <= cout + 6'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.txd  = txd_q;
    assign bus.rts  = rts_q;
    assign bus.done = done_q;
    assign bus.cout = cout;
    assign bus.busy = (state != IDLE);
    assign bus.max  = (state == DATA) && (cout == LAST_D);
endmodule

// File: tb/tb_usrt_tx_ctrl.sv
// Bench for usrt_tx_ctrl: two instances (1 stop/even, 2 stop/odd) share stimulus
// and are checked every cycle against a frame-list model, plus literal pins.
module tb_usrt_tx_ctrl;
    logic       clk = 1'b0;
    logic       rst, start, par_en, en, cts;
    logic [7:0] din;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    usrt_tx_ctrl_if #(.DATA_W(8)) bus0 ();
    usrt_tx_ctrl_if #(.DATA_W(8)) bus1 ();

    assign bus0.start = start;  assign bus1.start = start;
    assign bus0.din = din;      assign bus1.din = din;
    assign bus0.par_en = par_en; assign bus1.par_en = par_en;
    assign bus0.en_usrt = en;   assign bus1.en_usrt = en;
    assign bus0.cts = cts;      assign bus1.cts = cts;

    usrt_tx_ctrl #(.DATA_W(8), .STOP_BITS(1), .PAR_ODD(0)) u0 (.clk(clk), .rst(rst), .bus(bus0));
    usrt_tx_ctrl #(.DATA_W(8), .STOP_BITS(2), .PAR_ODD(1)) u1 (.clk(clk), .rst(rst), .bus(bus1));

    logic [1:0] o_txd, o_rts, o_busy, o_done, o_max;
    logic [5:0] o_cout [2];
    assign o_txd  = {bus1.txd, bus0.txd};
    assign o_rts  = {bus1.rts, bus0.rts};
    assign o_busy = {bus1.busy, bus0.busy};
    assign o_done = {bus1.done, bus0.done};
    assign o_max  = {bus1.max, bus0.max};
    assign o_cout[0] = bus0.cout;
    assign o_cout[1] = bus1.cout;

    task automatic chk(string nm, int i, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s[u%0d] got=%0h exp=%0h t=%0t", nm, i, got, exp, $time);
    endtask

    // Model: each accepted frame is a list of line bits; pos = bit now on txd
    // (-1 while waiting for cts). Field offsets give cout and max.
    bit fr [2][16];
    int flen [2];
    int plen [2];
    int pos  [2] = '{-1, -1};
    bit act  [2] = '{1'b0, 1'b0};
    bit mdone[2] = '{1'b0, 1'b0};

    function automatic logic e_txd(int i);
        return (act[i] && pos[i] >= 0) ? fr[i][pos[i]] : 1'b1;
    endfunction

    function automatic logic [5:0] e_cout(int i);
        if (act[i] && pos[i] >= 1 && pos[i] <= 8) return 6'(pos[i] - 1);
        if (act[i] && pos[i] >= 9 + plen[i])      return 6'(pos[i] - 9 - plen[i]);
        return 6'd0;
    endfunction

    task automatic model_step(int i);
        int n;
        mdone[i] = 1'b0;
        if (!rst) begin
            act[i] = 1'b0;
            pos[i] = -1;
        end else if (!act[i]) begin
            if (start) begin
                fr[i][0] = 1'b0;
                for (int b = 0; b < 8; b++) fr[i][1+b] = din[b];
                n = 9;
                plen[i] = par_en ? 1 : 0;
                if (par_en) begin
                    fr[i][n] = (^din) ^ (i == 1);
                    n++;
                end
                for (int s = 0; s < i + 1; s++) begin
                    fr[i][n] = 1'b1;
                    n++;
                end
                flen[i] = n;
                act[i]  = 1'b1;
                pos[i]  = -1;
            end
        end else if (en) begin
            if (pos[i] < 0) begin
                if (cts) pos[i] = 0;
            end else begin
                pos[i]++;
                if (pos[i] == flen[i]) begin
                    act[i]   = 1'b0;
                    pos[i]   = -1;
                    mdone[i] = 1'b1;
                end
            end
        end
    endtask

    // Inputs change 2 time units after posedge, so at negedge they are the
    // values the next posedge will sample.
    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                chk("txd",  i, 32'(o_txd[i]),  32'(e_txd(i)));
                chk("rts",  i, 32'(o_rts[i]),  32'(act[i]));
                chk("busy", i, 32'(o_busy[i]), 32'(act[i]));
                chk("done", i, 32'(o_done[i]), 32'(mdone[i]));
                chk("cout", i, 32'(o_cout[i]), 32'(e_cout(i)));
                chk("max",  i, 32'(o_max[i]),  32'(act[i] && pos[i] == 8));
            end
            for (int i = 0; i < 2; i++) model_step(i);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    logic [15:0] cap_txd, cap_max, cap_done;

    task automatic strobe(int s);
        en = 1'b1;
        @(posedge clk);
        #2;
        if (s >= 0 && s < 16) begin
            cap_txd[s]  = bus0.txd;
            cap_max[s]  = bus0.max;
            cap_done[s] = bus0.done;
        end
        en = 1'b0;
        tick();
    endtask

    task automatic strobes(int n);
        for (int s = 0; s < n; s++) strobe(s);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        // T1: reset held with noisy inputs
        rst = 1'b0; start = 1'b1; din = 8'($urandom); par_en = 1'b1; en = 1'b1; cts = 1'b1;
        tick();
        tick();
        chk("t1_txd",  0, 32'(bus0.txd), 32'd1);
        chk("t1_busy", 0, 32'(bus0.busy), 32'd0);
        chk("t1_rts",  1, 32'(bus1.rts), 32'd0);
        chk("t1_cout", 1, 32'(bus1.cout), 32'd0);
        rst = 1'b1; start = 1'b0; en = 1'b0;
        tick();

        // T2: A5 with even parity; din/par_en changed after acceptance
        cap_txd = '0; cap_max = '0; cap_done = '0;
        din = 8'hA5; par_en = 1'b1; cts = 1'b1;
        pulse_start();
        din = 8'h3C; par_en = 1'b0;
        strobes(12);
        chk("t2_txd_seq", 0, 32'(cap_txd[10:0]), 32'b10101001010);
        chk("t2_max_seq", 0, 32'(cap_max[10:0]), 32'h100);
        chk("t2_done",    0, 32'(cap_done[11:0]), 32'h800);
        strobes(3);

        // T3: 01 without parity; done follows the edge ending the stop bit
        cap_txd = '0; cap_done = '0;
        din = 8'h01; par_en = 1'b0;
        pulse_start();
        strobes(11);
        chk("t3_txd_seq", 0, 32'(cap_txd[9:0]), 32'b1000000010);
        chk("t3_done",    0, 32'(cap_done[10:0]), 32'h400);
        strobes(3);

        // T4: held off by cts, then cts dropped mid-frame
        cts = 1'b0; din = 8'h5A; par_en = 1'b1;
        pulse_start();
        strobes(5);
        chk("t4_hold_txd",  0, 32'(bus0.txd), 32'd1);
        chk("t4_hold_busy", 0, 32'(bus0.busy), 32'd1);
        chk("t4_hold_rts",  1, 32'(bus1.rts), 32'd1);
        cts = 1'b1;
        strobe(0);
        chk("t4_start_bit", 0, 32'(bus0.txd), 32'd0);
        cts = 1'b0;
        strobes(14);
        chk("t4_end_busy", 1, 32'(bus1.busy), 32'd0);

        // T5: reset on the 4th data bit, then a normal frame
        cts = 1'b1; din = 8'hC3; par_en = 1'b0;
        pulse_start();
        strobes(5);
        chk("t5_mid_busy", 0, 32'(bus0.busy), 32'd1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("t5_rst_txd",  0, 32'(bus0.txd), 32'd1);
        chk("t5_rst_busy", 1, 32'(bus1.busy), 32'd0);
        chk("t5_rst_done", 0, 32'(bus0.done), 32'd0);
        din = 8'($urandom); par_en = 1'b1;
        pulse_start();
        strobes(15);

        // T6: start held, back-to-back frames, strobes every other clk
        din = 8'h00; par_en = 1'b1; cts = 1'b1; start = 1'b1;
        for (int c = 0; c < 160; c++) begin
            en = c[0];
            tick();
        end
        start = 1'b0;
        for (int c = 0; c < 60; c++) begin
            en = c[0];
            tick();
        end
        en = 1'b0;
        tick();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
